// File: rtl/debug_loader_pkg.sv
// Shared types and constants for the debug program loader.
package debug_loader_pkg;

    // Controller states; the encoding is visible on o_state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Command bytes accepted in IDLE and DONE.
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

    // Top-six-bit opcode that terminates a program image.
    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

endpackage

// File: rtl/debug_loader_fsm_if.sv
// Bus bundle between the UART receiver, the loader and the pipeline debug ports.
// master: the loader itself; slave: the surrounding UART/pipeline side.
interface debug_loader_fsm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_rx_ready;
    logic                  i_halt;
    logic [DATA_WIDTH-1:0] o_inst_load;
    logic [ADDR_WIDTH-1:0] o_addr_inst_load;
    logic                  o_en_write;
    logic                  o_debug_unit;
    logic                  o_enable_pipe;
    logic                  o_en_read;
    logic [CNT_WIDTH-1:0]  o_count_cycles;
    logic                  o_load_done;
    logic                  o_overflow;
    logic [2:0]            o_state;

    modport master (
        input  i_rx_data, i_rx_valid, i_halt,
        output o_rx_ready, o_inst_load, o_addr_inst_load, o_en_write,
               o_debug_unit, o_enable_pipe, o_en_read, o_count_cycles,
               o_load_done, o_overflow, o_state
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_halt,
        input  o_rx_ready, o_inst_load, o_addr_inst_load, o_en_write,
               o_debug_unit, o_enable_pipe, o_en_read, o_count_cycles,
               o_load_done, o_overflow, o_state
    );
endinterface

// File: rtl/debug_loader_fsm_byte_word_assembler.sv
// Packs an MSB-first byte stream into DATA_WIDTH-bit words.
// word_valid is high in the same cycle as the byte that completes a word,
// so the controller can leave LOAD on that edge without an extra cycle.
module byte_word_assembler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            rx_byte,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [BCW-1:0]        byte_cnt;
    logic [DATA_WIDTH-1:0] word_next;

    generate
        if (DATA_WIDTH > 8) begin : g_wide
            assign word_next = {word[DATA_WIDTH-9:0], rx_byte};
        end else begin : g_narrow
            assign word_next = rx_byte;
        end
    endgenerate

    assign word_valid = shift_en && (byte_cnt == BCW'(NBYTES - 1));

    // Shift each accepted byte in from the LSB side and count bytes per word.
    always_ff @(posedge clock) begin
        if (!i_reset || clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= word_next;
            byte_cnt <= word_valid ? '0 : byte_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/debug_loader_fsm.sv
// Debug program loader and run controller.
// Loads instruction words from the debug UART into instruction memory until
// a HALT word (or memory full), then runs the pipeline and counts cycles.
// Build option: define STEP_MODE_EN to enable the single-step 'S' command.
module debug_loader_fsm
    import debug_loader_pkg::*;
#(
    parameter int         DATA_WIDTH  = 32,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         CNT_WIDTH   = 16,
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input logic                clock,
    input logic                i_reset,
    debug_loader_fsm_if.master bus
);
    state_t                state;
    logic                  rx_ready;
    logic                  en_write;
    logic                  debug_unit;
    logic                  enable_pipe;
    logic                  en_read;
    logic                  load_done;
    logic                  overflow;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] word;
    logic                  accept;
    logic                  load_cmd;
    logic                  shift_en;
    logic                  word_valid;

    function automatic logic is_halt(input logic [DATA_WIDTH-1:0] w);
        return w[DATA_WIDTH-1 -: 6] == HALT_OPCODE;
    endfunction

    // Cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept   = bus.i_rx_valid && rx_ready;
    assign load_cmd = accept && (state == ST_IDLE || state == ST_DONE)
                      && (bus.i_rx_data == CMD_LOAD);
    assign shift_en = accept && (state == ST_LOAD);

    byte_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_assembler (
        .clock      (clock),
        .i_reset    (i_reset),
        .clear      (load_cmd),
        .shift_en   (shift_en),
        .rx_byte    (bus.i_rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Controller: state plus every registered output.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            rx_ready    <= 1'b1;
            en_write    <= 1'b0;
            debug_unit  <= 1'b0;
            enable_pipe <= 1'b0;
            en_read     <= 1'b0;
            load_done   <= 1'b0;
            overflow    <= 1'b0;
            addr        <= '0;
            count       <= '0;
        end else begin
            en_write <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_cmd) begin
                        state      <= ST_LOAD;
                        addr       <= '0;
                        load_done  <= 1'b0;
                        overflow   <= 1'b0;
                        count      <= '0;
                        debug_unit <= 1'b1;
                    end else if (accept && state == ST_IDLE && load_done
                                 && bus.i_rx_data == CMD_RUN) begin
                        state       <= ST_RUN;
                        rx_ready    <= 1'b0;
                        enable_pipe <= 1'b1;
                        en_read     <= 1'b1;
                    end
`ifdef STEP_MODE_EN
                    else if (accept && state == ST_IDLE && load_done
                             && bus.i_rx_data == CMD_STEP) begin
                        state       <= ST_STEP;
                        rx_ready    <= 1'b0;
                        enable_pipe <= 1'b1;
                        en_read     <= 1'b1;
                    end
`endif
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        state    <= ST_WRITE;
                        rx_ready <= 1'b0;
                        en_write <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    rx_ready <= 1'b1;
                    if (is_halt(word)) begin
                        load_done  <= 1'b1;
                        debug_unit <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (&addr) begin
                        // Memory full without a HALT word: stop, do not wrap.
                        overflow   <= 1'b1;
                        debug_unit <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (enable_pipe) begin
                        count <= sat_inc(count);
                    end
                    if (bus.i_halt) begin
                        enable_pipe <= 1'b0;
                        en_read     <= 1'b0;
                        rx_ready    <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
`ifdef STEP_MODE_EN
                ST_STEP: begin
                    // Single enable pulse; a halt seen during it ends the program.
                    count       <= sat_inc(count);
                    enable_pipe <= 1'b0;
                    en_read     <= 1'b0;
                    rx_ready    <= 1'b1;
                    state       <= bus.i_halt ? ST_DONE : ST_IDLE;
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    rx_ready    <= 1'b1;
                    enable_pipe <= 1'b0;
                    en_read     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rx_ready       = rx_ready;
    assign bus.o_inst_load      = word;
    assign bus.o_addr_inst_load = addr;
    assign bus.o_en_write       = en_write;
    assign bus.o_debug_unit     = debug_unit;
    assign bus.o_enable_pipe    = enable_pipe;
    assign bus.o_en_read        = en_read;
    assign bus.o_count_cycles   = count;
    assign bus.o_load_done      = load_done;
    assign bus.o_overflow       = overflow;
    assign bus.o_state          = state;
endmodule
